// File: rtl/wb_split_pkg.sv
// wb_split_pkg: shared types and default constants for the Wishbone 1-to-N splitter
package wb_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int          MAX_NSLV        = 8;
    localparam logic [31:0] DEFAULT_DATA_C  = 32'hDEADBEEF;
    localparam logic [14:0] SLV_SEL_DEFAULT = {3'b101, 3'b100, 3'b010, 3'b001, 3'b000};

endpackage

// File: rtl/wb_split_decode.sv
// wb_split_decode: priority decoder mapping the address select field to a slave index
module wb_split_decode
    import wb_split_pkg::*;
#(
    parameter int                    NSLV    = 5,
    parameter int                    SEL_W   = 3,
    parameter logic [NSLV*SEL_W-1:0] SLV_SEL = SLV_SEL_DEFAULT,
    parameter int                    IDXW    = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic             hit_o,
    output logic [IDXW-1:0]  idx_o
);

    // Scan from the top index down so the lowest matching index overrides duplicates
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (sel_i == SLV_SEL[i*SEL_W +: SEL_W]) begin
                hit_o = 1'b1;
                idx_o = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_split_n.sv
// wb_split_n: Wishbone 1-to-N splitter with registered response, miss/timeout termination and error irq
module wb_split_n
    import wb_split_pkg::*;
#(
    parameter int                    NSLV         = 5,
    parameter int                    SEL_LSB      = 17,
    parameter int                    SEL_W        = 3,
    parameter logic [NSLV*SEL_W-1:0] SLV_SEL      = SLV_SEL_DEFAULT,
    parameter int                    TIMEOUT      = 255,
    parameter logic [31:0]           DEFAULT_DATA = DEFAULT_DATA_C
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [NSLV-1:0]    m_cyc_o,
    output logic [NSLV-1:0]    m_stb_o,
    output logic [31:0]        m_adr_o,
    output logic [31:0]        m_dat_o,
    output logic               m_we_o,
    output logic [3:0]         m_sel_o,
    input  logic [NSLV-1:0]    m_ack_i,
    input  logic [NSLV*32-1:0] m_dat_i,
    output logic               err_o,
    output logic [31:0]        err_adr_o,
    input  logic               err_clr_i,
    output logic               irq_o
);

    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     err_adr_q, err_adr_d;
    logic            err_q, err_d;
    logic            irq_q, irq_d;
    logic            err_set;
    logic            dec_hit;
    logic [IDXW-1:0] dec_idx;

    wb_split_decode #(
        .NSLV    (NSLV),
        .SEL_W   (SEL_W),
        .SLV_SEL (SLV_SEL),
        .IDXW    (IDXW)
    ) u_decode (
        .sel_i (wbs_adr_i[SEL_LSB +: SEL_W]),
        .hit_o (dec_hit),
        .idx_o (dec_idx)
    );

    // Only the selected slave sees cyc/stb, and only while BUSY, so reset drops it at once
    assign m_cyc_o   = (state_q == BUSY) ? (NSLV'(1) << idx_q) : '0;
    assign m_stb_o   = m_cyc_o;
    assign m_adr_o   = wbs_adr_i;
    assign m_dat_o   = wbs_dat_i;
    assign m_we_o    = wbs_we_i;
    assign m_sel_o   = wbs_sel_i;
    assign wbs_ack_o = (state_q == RESP);
    assign wbs_dat_o = dat_q;
    assign err_o     = err_q;
    assign err_adr_o = err_adr_q;
    assign irq_o     = irq_q;

    // Next-state: decode in IDLE, wait for ack/timeout/abort in BUSY, single ack cycle in RESP
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        adr_d     = adr_q;
        err_d     = err_q & ~err_clr_i;
        err_adr_d = err_adr_q;
        irq_d     = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d = wbs_adr_i;
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        dat_d   = DEFAULT_DATA;
                        err_set = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (m_ack_i[idx_q]) begin
                    dat_d   = m_dat_i[idx_q*32 +: 32];
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    dat_d   = DEFAULT_DATA;
                    err_set = 1'b1;
                    state_d = RESP;
                end else if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (err_set) begin
            err_d     = 1'b1;
            err_adr_d = (state_q == IDLE) ? wbs_adr_i : adr_q;
            irq_d     = 1'b1;
        end
    end

    // State and response registers with asynchronous active-low reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            adr_q     <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            adr_q     <= adr_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_wb_split_n.sv
// tb_wb_split_n: table-driven directed bench for wb_split_n with TIMEOUT=4
module tb_wb_split_n;

    localparam int NSLV = 5;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        int          slv;
        int          k;
        logic [31:0] sdat;
        int          exp_cyc;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        exp_irq;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]         wbs_sel_i = 4'hF;
    logic [31:0]        wbs_adr_i = '0, wbs_dat_i = '0;
    logic               wbs_ack_o;
    logic [31:0]        wbs_dat_o;
    logic [NSLV-1:0]    m_cyc_o, m_stb_o;
    logic [31:0]        m_adr_o, m_dat_o;
    logic               m_we_o;
    logic [3:0]         m_sel_o;
    logic [NSLV-1:0]    m_ack_i = '0;
    logic [NSLV*32-1:0] m_dat_i = '0;
    logic               err_o;
    logic [31:0]        err_adr_o;
    logic               err_clr_i = 1'b0;
    logic               irq_o;

    int checks = 0;
    int failures = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    wb_split_n #(.TIMEOUT(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .m_cyc_o    (m_cyc_o),
        .m_stb_o    (m_stb_o),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_we_o     (m_we_o),
        .m_sel_o    (m_sel_o),
        .m_ack_i    (m_ack_i),
        .m_dat_i    (m_dat_i),
        .err_o      (err_o),
        .err_adr_o  (err_adr_o),
        .err_clr_i  (err_clr_i),
        .irq_o      (irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int              n;
        int              got;
        logic [31:0]     gd, ga;
        logic            ge, gi;
        logic [NSLV-1:0] seen;
        wbs_adr_i = v.adr;
        wbs_we_i  = v.we;
        wbs_dat_i = 32'h5555_0000 | id;
        for (int j = 0; j < NSLV; j++) m_dat_i[j*32 +: 32] = 32'hBAD0_0000 | j;
        if (v.slv >= 0) m_dat_i[v.slv*32 +: 32] = v.sdat;
        m_ack_i   = '0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        n = 0; got = -1; seen = '0; gd = '0; ga = '0; ge = 1'b0; gi = 1'b0;
        while (n < 20 && got < 0) begin
            @(posedge clk); #1;
            n++;
            seen |= m_stb_o;
            if (wbs_ack_o) begin
                got = n; gd = wbs_dat_o; ge = err_o; gi = irq_o; ga = err_adr_o;
            end else begin
                m_ack_i = (v.slv >= 0 && n == v.k) ? (NSLV'(1) << v.slv) : '0;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_ack_i   = '0;
        chk($sformatf("v%0d ack_cycle", id), got, v.exp_cyc);
        chk($sformatf("v%0d rdata", id), gd, v.exp_dat);
        chk($sformatf("v%0d err", id), ge, v.exp_err);
        chk($sformatf("v%0d irq", id), gi, v.exp_irq);
        chk($sformatf("v%0d stb_seen", id), seen, (v.slv >= 0) ? (NSLV'(1) << v.slv) : '0);
        if (v.exp_irq) chk($sformatf("v%0d err_adr", id), ga, v.adr);
        @(posedge clk); #1;
        chk($sformatf("v%0d ack_one_cycle", id), wbs_ack_o, 1'b0);
        chk($sformatf("v%0d irq_one_cycle", id), irq_o, 1'b0);
    endtask

    initial begin
        logic any_ack;
        vecs[0] = '{32'h0004_0010, 1'b0,  2,  1, 32'h1234_5678, 2, 32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{32'h0002_0004, 1'b0,  1,  3, 32'hA5A5_0001, 4, 32'hA5A5_0001, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0100, 1'b0,  0,  4, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[3] = '{32'h000A_0000, 1'b1,  4,  2, 32'h0000_4444, 3, 32'h0000_4444, 1'b0, 1'b0};
        vecs[4] = '{32'h0006_0000, 1'b0, -1, -1, 32'h0,         1, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0200, 1'b0,  0, -1, 32'h0000_0777, 5, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[6] = '{32'h0008_0008, 1'b0,  3,  1, 32'h3333_3333, 2, 32'h3333_3333, 1'b1, 1'b0};
        vecs[7] = '{32'h000E_0004, 1'b1, -1, -1, 32'h0,         1, 32'hDEAD_BEEF, 1'b1, 1'b1};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", wbs_ack_o, 1'b0);
        chk("rst stb", m_stb_o, '0);
        chk("rst cyc", m_cyc_o, '0);
        chk("rst err", err_o, 1'b0);
        chk("rst irq", irq_o, 1'b0);
        chk("rst dat", wbs_dat_o, 32'h0);
        chk("rst err_adr", err_adr_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        // Stray slave acks with no transaction in flight are ignored
        m_ack_i = '1;
        any_ack = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            any_ack |= wbs_ack_o;
        end
        m_ack_i = '0;
        chk("stray ack ignored", any_ack, 1'b0);
        chk("dat hold", wbs_dat_o, 32'hDEAD_BEEF);

        // Master abort during BUSY
        wbs_adr_i = 32'h0002_0000;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("abort busy stb", m_stb_o, 5'b00010);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("abort stb drop", m_stb_o, '0);
        any_ack = wbs_ack_o;
        repeat (3) begin
            @(posedge clk); #1;
            any_ack |= wbs_ack_o;
        end
        chk("abort no ack", any_ack, 1'b0);

        // Clear then clear-with-new-error
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        chk("err cleared", err_o, 1'b0);
        wbs_adr_i = 32'h0006_0000;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        chk("set beats clr err", err_o, 1'b1);
        chk("set beats clr ack", wbs_ack_o, 1'b1);
        chk("set beats clr irq", irq_o, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset mid-BUSY
        wbs_adr_i = 32'h0008_0000;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        chk("pre-reset stb", m_stb_o, 5'b01000);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst stb", m_stb_o, '0);
        chk("async rst cyc", m_cyc_o, '0);
        chk("async rst ack", wbs_ack_o, 1'b0);
        chk("async rst err", err_o, 1'b0);
        chk("async rst err_adr", err_adr_o, 32'h0);
        chk("async rst dat", wbs_dat_o, 32'h0);
        chk("async rst irq", irq_o, 1'b0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset ack", wbs_ack_o, 1'b0);
        chk("post-reset stb", m_stb_o, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
